// File: rtl/reg_id_ex_pkg.sv
// Shared ID/EX pipeline definitions: field widths, bubble opcode and the
// packed stage payload used by decode, this register and execute.
package reg_id_ex_pkg;

    localparam int OP_W  = 5;
    localparam int REG_W = 9;
    localparam int DIR_W = 27;

    localparam logic [OP_W-1:0] NOP_OP = 5'd0;

    typedef struct packed {
        logic [OP_W-1:0]  opcode;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [DIR_W-1:0] dir;
    } id_ex_t;

    localparam int ID_EX_W = $bits(id_ex_t);

    // A bubble carries the NOP opcode with every operand field cleared.
    localparam id_ex_t ID_EX_BUBBLE = id_ex_t'({NOP_OP, {(ID_EX_W - OP_W){1'b0}}});

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline flop: async active-low reset, load enable and a synchronous
// clear that takes priority over the enable. Clear loads the reset value.
module pipe_reg #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = RST_VAL;
        end else if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/reg_id_ex.sv
// ID/EX pipeline register: holds one decoded instruction for execute, with
// stall (en=0) and flush (bubble insert, wins over stall) for hazard handling.
module reg_id_ex
    import reg_id_ex_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [OP_W-1:0]  OpCode,
    input  logic [REG_W-1:0] Rd,
    input  logic [REG_W-1:0] Rs,
    input  logic [REG_W-1:0] Rt,
    input  logic [DIR_W-1:0] Dir,
    output logic [OP_W-1:0]  OpCodeOut,
    output logic [REG_W-1:0] RdOut,
    output logic [REG_W-1:0] RsOut,
    output logic [REG_W-1:0] RtOut,
    output logic [DIR_W-1:0] DirOut,
    output logic             ValidOut
);

    localparam int STAGE_W = ID_EX_W + 1;

    id_ex_t             stage_in;
    id_ex_t             stage_out;
    logic [STAGE_W-1:0] stage_q;

    assign stage_in.opcode = OpCode;
    assign stage_in.rd     = Rd;
    assign stage_in.rs     = Rs;
    assign stage_in.rt     = Rt;
    assign stage_in.dir    = Dir;

    // Valid rides in the LSB: a load always marks the stage as a real instruction.
    pipe_reg #(
        .W       (STAGE_W),
        .RST_VAL ({ID_EX_BUBBLE, 1'b0})
    ) u_pipe_reg (
        .clk   (clk),
        .rst_n (rst),
        .en    (en),
        .clr   (flush),
        .d     ({stage_in, 1'b1}),
        .q     (stage_q)
    );

    assign stage_out = stage_q[STAGE_W-1:1];
    assign ValidOut  = stage_q[0];

    assign OpCodeOut = stage_out.opcode;
    assign RdOut     = stage_out.rd;
    assign RsOut     = stage_out.rs;
    assign RtOut     = stage_out.rt;
    assign DirOut    = stage_out.dir;

endmodule

// File: tb/tb_reg_id_ex.sv
// Bench for reg_id_ex: behavioural expectation of the stage contents compared
// every cycle, plus directed vectors with literal expected values.
module tb_reg_id_ex;
    import reg_id_ex_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             flush = 1'b0;
    logic [OP_W-1:0]  OpCode = '0;
    logic [REG_W-1:0] Rd = '0;
    logic [REG_W-1:0] Rs = '0;
    logic [REG_W-1:0] Rt = '0;
    logic [DIR_W-1:0] Dir = '0;
    logic [OP_W-1:0]  OpCodeOut;
    logic [REG_W-1:0] RdOut;
    logic [REG_W-1:0] RsOut;
    logic [REG_W-1:0] RtOut;
    logic [DIR_W-1:0] DirOut;
    logic             ValidOut;

    int checks = 0;
    int errors = 0;

    // Expected stage contents, evolved from the observable rules only.
    logic [31:0] mOp = 0, mRd = 0, mRs = 0, mRt = 0, mDir = 0, mValid = 0;

    reg_id_ex dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .OpCode    (OpCode),
        .Rd        (Rd),
        .Rs        (Rs),
        .Rt        (Rt),
        .Dir       (Dir),
        .OpCodeOut (OpCodeOut),
        .RdOut     (RdOut),
        .RsOut     (RsOut),
        .RtOut     (RtOut),
        .DirOut    (DirOut),
        .ValidOut  (ValidOut)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst || flush) begin
            mOp = 0; mRd = 0; mRs = 0; mRt = 0; mDir = 0; mValid = 0;
        end else if (en) begin
            mOp = 32'(OpCode); mRd = 32'(Rd); mRs = 32'(Rs); mRt = 32'(Rt);
            mDir = 32'(Dir); mValid = 1;
        end
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        checkVal("model_op",    32'(OpCodeOut), mOp);
        checkVal("model_rd",    32'(RdOut),     mRd);
        checkVal("model_rs",    32'(RsOut),     mRs);
        checkVal("model_rt",    32'(RtOut),     mRt);
        checkVal("model_dir",   32'(DirOut),    mDir);
        checkVal("model_valid", 32'(ValidOut),  mValid);
    end

    task automatic applyStimulus(input int op, input int rd, input int rs, input int rt, input int dir);
        OpCode = OP_W'(op);
        Rd     = REG_W'(rd);
        Rs     = REG_W'(rs);
        Rt     = REG_W'(rt);
        Dir    = DIR_W'(dir);
    endtask

    task automatic checkOutput(input string name, input int op, input int rd, input int rs,
                               input int rt, input int dir, input int valid);
        checkVal({name, "_op"},    32'(OpCodeOut), 32'(op));
        checkVal({name, "_rd"},    32'(RdOut),     32'(rd));
        checkVal({name, "_rs"},    32'(RsOut),     32'(rs));
        checkVal({name, "_rt"},    32'(RtOut),     32'(rt));
        checkVal({name, "_dir"},   32'(DirOut),    32'(dir));
        checkVal({name, "_valid"}, 32'(ValidOut),  32'(valid));
    endtask

    initial begin
        // Reset held through the first edge.
        @(negedge clk);
        checkOutput("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b1;

        // Back-to-back loads.
        en = 1'b1;
        applyStimulus(3, 1, 2, 3, 11);
        @(negedge clk);
        checkOutput("load1", 3, 1, 2, 3, 11, 1);
        applyStimulus(11, 6, 9, 8, 14);
        @(negedge clk);
        checkOutput("load2", 11, 6, 9, 8, 14, 1);
        applyStimulus(7, 9, 7, 5, 128);
        @(negedge clk);
        checkOutput("load3", 7, 9, 7, 5, 128, 1);

        // Stall for three edges while the inputs move.
        applyStimulus(11, 6, 9, 8, 14);
        @(negedge clk);
        en = 1'b0;
        applyStimulus(7, 9, 7, 5, 128);
        repeat (3) @(negedge clk);
        checkOutput("stall", 11, 6, 9, 8, 14, 1);

        // Flush wins over stall, then a normal load resumes.
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush", 0, 0, 0, 0, 0, 0);
        flush = 1'b0;
        en = 1'b1;
        @(negedge clk);
        checkOutput("after_flush", 7, 9, 7, 5, 128, 1);

        // Inputs change in the same timestep as the edge: pre-edge value wins.
        applyStimulus(3, 1, 2, 3, 11);
        @(posedge clk);
        OpCode <= 5'd11; Rd <= 9'd6; Rs <= 9'd9; Rt <= 9'd8; Dir <= 27'd14;
        @(negedge clk);
        checkOutput("edge_same", 3, 1, 2, 3, 11, 1);
        @(negedge clk);
        checkOutput("edge_next", 11, 6, 9, 8, 14, 1);

        // All-ones fields pass through bit-exactly.
        applyStimulus(32'h1F, 32'h1FF, 32'h1FF, 32'h1FF, 32'h7FF_FFFF);
        @(negedge clk);
        checkOutput("max", 32'h1F, 32'h1FF, 32'h1FF, 32'h1FF, 32'h7FF_FFFF, 1);

        // Asynchronous reset mid-cycle, held across an edge, then released.
        #2 rst = 1'b0;
        #1 checkOutput("async_rst", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 checkOutput("rst_hold", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_release", 32'h1F, 32'h1FF, 32'h1FF, 32'h1FF, 32'h7FF_FFFF, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_id_ex.md
Name: reg_id_ex

Overview:
- ID/EX pipeline register of the grouped-processor pipeline; sits between instruction decode and execute.
- Captures decoded opcode, three register operand fields and the address/immediate field on each rising clock edge; presents them to EX for one full cycle.
- Supports stall (hold) and flush (bubble insertion) for hazard handling.

Parameters:
- OP_W, 5, opcode field width
- REG_W, 9, width of each of Rd/Rs/Rt fields
- DIR_W, 27, width of address/immediate field
- NOP_OP, 5'd0, opcode value loaded on reset/flush (bubble)

Ports:
- clk  in  1  pipeline clock, rising-edge active
- rst  in  1  asynchronous, active-low reset
- en  in  1  load enable; 0 = stall (hold contents)
- flush  in  1  synchronous bubble insert
- OpCode  in  OP_W  decoded opcode from ID
- Rd  in  REG_W  destination field from ID
- Rs  in  REG_W  source-1 field from ID
- Rt  in  REG_W  source-2 field from ID
- Dir  in  DIR_W  address/immediate from ID
- OpCodeOut  out  OP_W  registered opcode to EX
- RdOut  out  REG_W  registered Rd
- RsOut  out  REG_W  registered Rs
- RtOut  out  REG_W  registered Rt
- DirOut  out  DIR_W  registered Dir
- ValidOut  out  1  1 = stage holds a real instruction, 0 = bubble

Behaviour:
- All outputs registered; no combinational input-to-output path.
- rst low: immediately (asynchronously) OpCodeOut=NOP_OP, RdOut/RsOut/RtOut/DirOut=0, ValidOut=0. Held while rst low, independent of clk.
- rst deassertion: first rising edge with rst high performs a normal update.
- Priority at each rising edge with rst high: flush > stall > load.
- flush=1: load bubble (same values as reset), regardless of en.
- flush=0, en=0: all outputs hold previous values.
- flush=0, en=1: all outputs take the input values sampled at the edge; ValidOut=1.
- Latency: exactly one clock edge from input to output.
- Inputs changing in the same timestep as the edge: the pre-edge value is captured (nonblocking semantics).
- Field widths pass through unchanged; no sign extension, truncation or arithmetic.
- Inputs with X/Z propagate as-is; no checking.

Decomposition:
- Shared pipeline package: OP_W, REG_W, DIR_W, NOP_OP constants, plus a packed struct id_ex_t {opcode, rd, rs, rt, dir} that ID and EX also use.
- Natural sub-module: pipe_reg, a generic width-parameterised flop with async active-low reset, enable and synchronous clear. reg_id_ex instantiates it once on the packed struct plus the valid bit.

Test Plan:
- Reset: assert rst low mid-cycle with outputs non-zero -> outputs go to 0/NOP and ValidOut=0 immediately, without waiting for a clock edge.
- Load sequence, en=1: drive (3,1,2,3,11), then (11,6,9,8,14), then (7,9,7,5,128) one per cycle -> outputs match each set one edge later, ValidOut=1.
- Stall: load (11,6,9,8,14), set en=0, change inputs to (7,9,7,5,128) for 3 edges -> outputs stay (11,6,9,8,14).
- Flush priority: flush=1 with en=0 and inputs (7,9,7,5,128) -> next edge outputs all 0, ValidOut=0. Flush=0, en=1 -> next edge loads (7,9,7,5,128).
- Edge-coincident change: change inputs exactly at a rising edge from (3,1,2,3,11) to (11,6,9,8,14) -> outputs show (3,1,2,3,11) for that cycle.
- Max values: drive 5'h1F, 9'h1FF ×3, 27'h7FFFFFF -> outputs reproduce them bit-exactly.
